// File: rtl/terminal_writer.sv
// UART-byte command decoder feeding the text RAM write port: glyphs, attribute commands, controls.
// Optional full-screen clear on 8'h0C is built only when TERMINAL_WRITER_CLEAR_EN is defined.
module terminal_writer #(
  parameter int         COLUMNS      = 80,
  parameter int         ROWS         = 30,
  parameter int         ADDR_WIDTH   = 12,
  parameter logic [7:0] DEFAULT_ATTR = 8'h70
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            RxData_i,
  input  logic                  RxDone_i,
  output logic                  WrEnable_o,
  output logic [ADDR_WIDTH-1:0] WrAddress_o,
  output logic [15:0]           WrData_o,
  output logic [ADDR_WIDTH-1:0] Cursor_o,
  output logic                  Busy_o,
  output logic                  Overrun_o
);

  localparam int COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(COLUMNS * ROWS - 1);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
  logic [7:0]            attr_q, attr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

`ifdef TERMINAL_WRITER_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
`endif

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    cursor_d  = cursor_q;
    attr_d    = attr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = 1'b0;
    overrun_d = 1'b0;
`ifdef TERMINAL_WRITER_CLEAR_EN
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_addr_q;
      wr_data_d = {attr_q, 8'h20};
      busy_d    = 1'b1;
      overrun_d = RxDone_i;
      if (clr_addr_q == ADDR_LAST) begin
        state_d  = IDLE;
        cursor_d = '0;
        col_d    = '0;
        row_d    = '0;
      end else begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      end
    end else
`endif
    if (RxDone_i) begin
      if (RxData_i[7]) begin
        attr_d = {1'b0, RxData_i[6:0]};
      end else if (RxData_i == 8'h08) begin
        if (cursor_q != '0) begin
          cursor_d  = cursor_q - ADDR_WIDTH'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = cursor_q - ADDR_WIDTH'(1);
          wr_data_d = {attr_q, 8'h20};
          if (col_q == '0) begin
            col_d = COL_LAST;
            row_d = row_q - ROW_W'(1);
          end else begin
            col_d = col_q - COL_W'(1);
          end
        end
      end else if (RxData_i == 8'h0D) begin
        col_d = '0;
        // Start of the next row is reached by rewinding the column, not by row*COLUMNS.
        if (row_q == ROW_LAST) begin
          row_d    = '0;
          cursor_d = '0;
        end else begin
          row_d    = row_q + ROW_W'(1);
          cursor_d = cursor_q - ADDR_WIDTH'(col_q) + ADDR_WIDTH'(COLUMNS);
        end
      end
`ifdef TERMINAL_WRITER_CLEAR_EN
      else if (RxData_i == 8'h0C) begin
        // First clear write goes out with the same latency as a glyph.
        state_d    = CLEAR;
        wr_en_d    = 1'b1;
        wr_addr_d  = '0;
        wr_data_d  = {attr_q, 8'h20};
        busy_d     = 1'b1;
        clr_addr_d = ADDR_WIDTH'(1);
      end
`endif
      else begin
        wr_en_d   = 1'b1;
        wr_addr_d = cursor_q;
        wr_data_d = {attr_q, RxData_i};
        if (cursor_q == ADDR_LAST) begin
          cursor_d = '0;
          col_d    = '0;
          row_d    = '0;
        end else begin
          cursor_d = cursor_q + ADDR_WIDTH'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col_q     <= '0;
      row_q     <= '0;
      cursor_q  <= '0;
      attr_q    <= DEFAULT_ATTR;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      cursor_q  <= cursor_d;
      attr_q    <= attr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef TERMINAL_WRITER_CLEAR_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end
`endif

  assign WrEnable_o  = wr_en_q;
  assign WrAddress_o = wr_addr_q;
  assign WrData_o    = wr_data_q;
  assign Cursor_o    = cursor_q;
  assign Busy_o      = busy_q;
  assign Overrun_o   = overrun_q;

endmodule
